// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_ctrl
// Brief    : RV32I fetch sequencer: owns the fetch PC, drives a synchronous
//            instruction ROM and presents PC/instruction/valid to decode.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_DEPTH = 10,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        irom_en,
    output logic [31:0] irom_adr,
    input  logic [31:0] irom_inst,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_fault,
    output logic [1:0]  if_fault_cause
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] fetch_pc, fetch_pc_nx;
    logic [31:0] pend_pc, pend_pc_nx;
    logic        pend, pend_nx;
    logic        fault_pend, fault_pend_nx;
    logic [1:0]  cause_q, cause_nx;

    logic        issue;
    logic [31:0] issue_adr;
    logic        misaligned;
    logic        out_of_range;
    logic        legal;
    logic        live;

    // Address selection: a redirect wins over everything, including stall.
    always_comb begin
        issue     = 1'b0;
        issue_adr = fetch_pc;
        if (redirect) begin
            issue     = 1'b1;
            issue_adr = redirect_pc;
        end else begin
            case (state)
                BOOT: begin
                    issue     = 1'b1;
                    issue_adr = RESET_PC;
                end
                RUN:     issue = ~stall;
                default: issue = 1'b0;
            endcase
        end
    end

    assign misaligned   = (issue_adr[1:0] != 2'b00);
    assign out_of_range = ((issue_adr >> (ROM_DEPTH + 2)) != 32'd0);
    assign legal        = ~misaligned & ~out_of_range;

    assign irom_en  = issue & legal & ~rst;
    assign irom_adr = issue_adr;

    always_comb begin
        state_nx      = state;
        fetch_pc_nx   = fetch_pc;
        pend_nx       = pend;
        pend_pc_nx    = pend_pc;
        fault_pend_nx = fault_pend;
        cause_nx      = cause_q;
        if (issue) begin
            pend_pc_nx = issue_adr;
            if (legal) begin
                state_nx      = RUN;
                pend_nx       = 1'b1;
                fetch_pc_nx   = issue_adr + 32'd4;
                fault_pend_nx = 1'b0;
            end else begin
                // The faulting address is reported once, then fetch parks in HALT.
                state_nx      = HALT;
                pend_nx       = 1'b0;
                fault_pend_nx = 1'b1;
                cause_nx      = misaligned ? 2'd1 : 2'd2;
            end
        end else if ((state == HALT) && !stall) begin
            fault_pend_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            fetch_pc   <= RESET_PC;
            pend       <= 1'b0;
            pend_pc    <= RESET_PC;
            fault_pend <= 1'b0;
            cause_q    <= 2'd0;
        end else begin
            state      <= state_nx;
            fetch_pc   <= fetch_pc_nx;
            pend       <= pend_nx;
            pend_pc    <= pend_pc_nx;
            fault_pend <= fault_pend_nx;
            cause_q    <= cause_nx;
        end
    end

    // A redirect squashes whatever is on display this cycle.
    always_comb begin
        live = 1'b0;
        if (!redirect) begin
            case (state)
                RUN:     live = pend;
                HALT:    live = fault_pend;
                default: live = 1'b0;
            endcase
        end
    end

    assign if_valid       = live;
    assign if_pc          = pend_pc;
    assign if_fault       = live & (state == HALT);
    assign if_fault_cause = if_fault ? cause_q : 2'd0;
    assign if_inst        = (live && (state == RUN)) ? irom_inst : NOP_INST;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_ctrl
// Brief    : Directed vector bench for ifetch_ctrl with a synchronous ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        irom_en;
    logic [31:0] irom_adr;
    logic [31:0] irom_inst = 32'd0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fault;
    logic [1:0]  if_fault_cause;

    int checks = 0;
    int failures = 0;

    ifetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .ROM_DEPTH(10),
        .NOP_INST (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .irom_en       (irom_en),
        .irom_adr      (irom_adr),
        .irom_inst     (irom_inst),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_fault      (if_fault),
        .if_fault_cause(if_fault_cause)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rw(input int idx);
        return 32'hC0DE_0000 + idx;
    endfunction

    // Synchronous ROM: one-cycle latency, output holds while disabled.
    always @(posedge clk) begin
        if (irom_en) irom_inst <= rw(int'(irom_adr >> 2));
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        en;
        logic [31:0] adr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
        logic [1:0]  cause;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic s, input logic rd,
                               input logic [31:0] rpc, input logic en,
                               input logic [31:0] adr, input logic val,
                               input logic [31:0] pc, input logic [31:0] inst,
                               input logic flt, input logic [1:0] cause);
        vec_t t;
        t.rst = r; t.stall = s; t.redirect = rd; t.rpc = rpc;
        t.en = en; t.adr = adr; t.valid = val; t.pc = pc; t.inst = inst;
        t.fault = flt; t.cause = cause;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic en, input logic [31:0] adr,
                           input logic val, input logic [31:0] pc, input logic [31:0] inst,
                           input logic flt, input logic [1:0] cause);
        chk({tag, ".irom_en"}, {31'd0, irom_en}, {31'd0, en});
        if (en) chk({tag, ".irom_adr"}, irom_adr, adr);
        chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, val});
        chk({tag, ".if_pc"}, if_pc, pc);
        chk({tag, ".if_inst"}, if_inst, inst);
        chk({tag, ".if_fault"}, {31'd0, if_fault}, {31'd0, flt});
        chk({tag, ".cause"}, {30'd0, if_fault_cause}, {30'd0, cause});
    endtask

    initial begin
        //                 rst st rd rpc            en adr           val pc             inst         flt cause
        vecs.push_back(v(1, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         NOP,          0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          1, 32'h0,         0, 32'h0,         NOP,          0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          1, 32'h4,         1, 32'h0,         rw(0),        0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          1, 32'h8,         1, 32'h4,         rw(1),        0, 0));
        vecs.push_back(v(0, 1, 0, 32'h0,          0, 32'h0,         1, 32'h8,         rw(2),        0, 0));
        vecs.push_back(v(0, 1, 0, 32'h0,          0, 32'h0,         1, 32'h8,         rw(2),        0, 0));
        vecs.push_back(v(0, 1, 0, 32'h0,          0, 32'h0,         1, 32'h8,         rw(2),        0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          1, 32'hC,         1, 32'h8,         rw(2),        0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          1, 32'h10,        1, 32'hC,         rw(3),        0, 0));
        vecs.push_back(v(0, 1, 1, 32'h40,         1, 32'h40,        0, 32'h10,        NOP,          0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          1, 32'h44,        1, 32'h40,        rw(16),       0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          1, 32'h48,        1, 32'h44,        rw(17),       0, 0));
        vecs.push_back(v(0, 0, 1, 32'h42,         0, 32'h0,         0, 32'h48,        NOP,          0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h42,        NOP,          1, 1));
        vecs.push_back(v(0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h42,        NOP,          0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h42,        NOP,          0, 0));
        vecs.push_back(v(0, 0, 1, 32'h100,        1, 32'h100,       0, 32'h42,        NOP,          0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          1, 32'h104,       1, 32'h100,       rw(64),       0, 0));
        vecs.push_back(v(0, 0, 1, 32'hFF8,        1, 32'hFF8,       0, 32'h104,       NOP,          0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          1, 32'hFFC,       1, 32'hFF8,       rw(1022),     0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          0, 32'h0,         1, 32'hFFC,       rw(1023),     0, 0));
        vecs.push_back(v(0, 1, 0, 32'h0,          0, 32'h0,         1, 32'h1000,      NOP,          1, 2));
        vecs.push_back(v(0, 1, 0, 32'h0,          0, 32'h0,         1, 32'h1000,      NOP,          1, 2));
        vecs.push_back(v(0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h1000,      NOP,          1, 2));
        vecs.push_back(v(0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h1000,      NOP,          0, 0));
        vecs.push_back(v(0, 0, 1, 32'h2000_0000,  0, 32'h0,         0, 32'h1000,      NOP,          0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h2000_0000, NOP,          1, 2));
        vecs.push_back(v(0, 0, 1, 32'hFFFF_FFFE,  0, 32'h0,         0, 32'h2000_0000, NOP,          0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          0, 32'h0,         1, 32'hFFFF_FFFE, NOP,          1, 1));
        vecs.push_back(v(0, 1, 1, 32'h10,         1, 32'h10,        0, 32'hFFFF_FFFE, NOP,          0, 0));
        vecs.push_back(v(0, 1, 0, 32'h0,          0, 32'h0,         1, 32'h10,        rw(4),        0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          1, 32'h14,        1, 32'h10,        rw(4),        0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,          1, 32'h18,        1, 32'h14,        rw(5),        0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst         = vecs[i].rst;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].adr, vecs[i].valid,
                    vecs[i].pc, vecs[i].inst, vecs[i].fault, vecs[i].cause);
        end

        // Asynchronous reset while stalled mid-stream.
        @(negedge clk);
        stall = 1'b1; redirect = 1'b0;
        #1 chk_all("stall_pre", 1'b0, 32'h0, 1'b1, 32'h18, rw(6), 1'b0, 2'd0);
        #1 rst = 1'b1;
        #1 chk_all("stall_rst", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        #1 chk_all("stall_boot", 1'b1, 32'h0, 1'b0, 32'h0, NOP, 1'b0, 2'd0);
        @(negedge clk);
        #1 chk_all("stall_restart", 1'b1, 32'h4, 1'b1, 32'h0, rw(0), 1'b0, 2'd0);

        // Asynchronous reset while a fault is held in HALT.
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h3;
        #1 chk_all("halt_redir", 1'b0, 32'h0, 1'b0, 32'h4, NOP, 1'b0, 2'd0);
        @(negedge clk);
        redirect = 1'b0; stall = 1'b1;
        #1 chk_all("halt_fault", 1'b0, 32'h0, 1'b1, 32'h3, NOP, 1'b1, 2'd1);
        #1 rst = 1'b1;
        #1 chk_all("halt_rst", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        #1 chk_all("halt_boot", 1'b1, 32'h0, 1'b0, 32'h0, NOP, 1'b0, 2'd0);
        @(negedge clk);
        #1 chk_all("halt_restart", 1'b1, 32'h4, 1'b1, 32'h0, rw(0), 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
